m68k_bus_initiator: RTL and testbench

//  Initiator end of the 68000 asynchronous bus that the motherboard RAM decoder answers.

---
 rtl/m68k_bus_initiator_pkg.sv | 25 ++
 rtl/m68k_bus_initiator_if.sv | 38 +++
 rtl/m68k_bus_initiator_sync.sv | 22 ++
 rtl/m68k_bus_initiator.sv | 155 +++++++++++++++
 tb/tb_m68k_bus_initiator.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_bus_initiator_pkg.sv
// m68k_bus_pkg: shared types and defaults for the 68000 bus initiator.
// Holds the FSM state enum, byte-enable encodings, synchroniser depth and timeout default.
// No ports; imported by the initiator top and its interface users.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    WDS,
    WAIT,
    LATCH,
    RECOVER
  } state_t;

  // REQ_BE encodings {upper, lower}; BE_NONE is illegal on the request side.
  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  localparam int DEFAULT_SYNC    = 2;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/m68k_bus_initiator_if.sv
// m68k_bus_initiator_if: request/ack side plus 68000 socket side of the bus initiator.
// Request: REQ, REQ_RW, REQ_ADDR, REQ_BE, REQ_WDATA in; ACK, ERR, RDATA out.
// Bus: A_OUT, D_OUT, D_OE, AS_n, UDS_n, LDS_n, RW_n out; D_IN, DTACK_n, BERR_n in.
interface m68k_bus_initiator_if;

  logic        REQ;
  logic        REQ_RW;
  logic [22:0] REQ_ADDR;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA;
  logic        ACK;
  logic        ERR;
  logic [15:0] RDATA;

  logic [22:0] A_OUT;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW_n;
  logic        DTACK_n;
  logic        BERR_n;

  // master: the initiator itself
  modport master (
    input  REQ, REQ_RW, REQ_ADDR, REQ_BE, REQ_WDATA, D_IN, DTACK_n, BERR_n,
    output ACK, ERR, RDATA, A_OUT, D_OUT, D_OE, AS_n, UDS_n, LDS_n, RW_n
  );

  // slave: the requesting core together with the motherboard responder
  modport slave (
    output REQ, REQ_RW, REQ_ADDR, REQ_BE, REQ_WDATA, D_IN, DTACK_n, BERR_n,
    input  ACK, ERR, RDATA, A_OUT, D_OUT, D_OE, AS_n, UDS_n, LDS_n, RW_n
  );

endinterface

// File: rtl/m68k_bus_initiator_sync.sv
// sync_n: STAGES-deep flop synchroniser for an active-low asynchronous bus response.
// Latency: STAGES clk cycles; no backpressure. Resets to 1 (response negated).
// Ports: clk, rst_n (async active-low), d_n (async input), q_n (synchronised output).
module sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_n,
  output logic q_n
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '1;
    else        sr <= {sr[STAGES-2:0], d_n};
  end

  assign q_n = sr[STAGES-1];

endmodule

// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator: turns a level REQ/one-cycle ACK transfer into a full 68000 async bus cycle.
// Latency: REQ->ACK read 5 / write 6 CLK minimum, plus SYNC_STAGES-1 when DTACK_n answers the strobes.
// Backpressure: REQ is held until ACK; no new cycle starts until DTACK_n/BERR_n are released.
// Ports: CLK, RESET_n (async active-low), bus (m68k_bus_initiator_if.master).
// Optional BUS_TIMEOUT_EN: forces an ERR completion TIMEOUT_CYCLES after entering WAIT.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int SYNC_STAGES    = DEFAULT_SYNC,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  m68k_bus_initiator_if.master   bus
);

  state_t      state;
  logic        rd_q;
  logic [1:0]  be_q;
  logic        berr_q;
  logic [22:0] a_out;
  logic [15:0] d_out;
  logic        d_oe;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw_n;
  logic        ack;
  logic        err;
  logic [15:0] rdata;
  logic        dtack_s;
  logic        berr_s;

`ifdef BUS_TIMEOUT_EN
  // Leave WAIT two counts early: one edge to reach LATCH, one for ACK, so ACK
  // lands exactly TIMEOUT_CYCLES after entering WAIT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 2);
  logic [7:0] cnt;
`endif

  sync_n #(.STAGES(SYNC_STAGES)) u_sync_dtack (
    .clk(CLK), .rst_n(RESET_n), .d_n(bus.DTACK_n), .q_n(dtack_s)
  );

  sync_n #(.STAGES(SYNC_STAGES)) u_sync_berr (
    .clk(CLK), .rst_n(RESET_n), .d_n(bus.BERR_n), .q_n(berr_s)
  );

  // Every output is a register loaded on the edge that enters the state it
  // belongs to, so async reset negates strobes and D_OE without waiting for CLK.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state  <= IDLE;
      rd_q   <= 1'b1;
      be_q   <= BE_NONE;
      berr_q <= 1'b0;
      a_out  <= '0;
      d_out  <= '0;
      d_oe   <= 1'b0;
      as_n   <= 1'b1;
      uds_n  <= 1'b1;
      lds_n  <= 1'b1;
      rw_n   <= 1'b1;
      ack    <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            rd_q  <= bus.REQ_RW;
            be_q  <= bus.REQ_BE;
            a_out <= bus.REQ_ADDR;
            rw_n  <= bus.REQ_RW;
            if (!bus.REQ_RW) d_out <= bus.REQ_WDATA;
            state <= ADDR;
          end
        end
        ADDR: begin
          as_n <= 1'b0;
          if (rd_q) {uds_n, lds_n} <= ~be_q;
          else      d_oe <= 1'b1;
          state <= STRB;
        end
        STRB: begin
          if (rd_q) begin
            state <= WAIT;
`ifdef BUS_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else begin
            {uds_n, lds_n} <= ~be_q;
            state <= WDS;
          end
        end
        WDS: begin
          state <= WAIT;
`ifdef BUS_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          // BERR takes priority when both responses arrive together.
          if (!berr_s) begin
            berr_q <= 1'b1;
            state  <= LATCH;
          end else if (!dtack_s) begin
            berr_q <= 1'b0;
            state  <= LATCH;
          end
`ifdef BUS_TIMEOUT_EN
          else if (cnt == TMO_LAST) begin
            berr_q <= 1'b1;
            state  <= LATCH;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        LATCH: begin
          if (rd_q && !berr_q) rdata <= bus.D_IN;
          as_n  <= 1'b1;
          uds_n <= 1'b1;
          lds_n <= 1'b1;
          d_oe  <= 1'b0;
          rw_n  <= 1'b1;
          ack   <= 1'b1;
          err   <= berr_q;
          state <= RECOVER;
        end
        RECOVER: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (dtack_s && berr_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK   = ack;
  assign bus.ERR   = err;
  assign bus.RDATA = rdata;
  assign bus.A_OUT = a_out;
  assign bus.D_OUT = d_out;
  assign bus.D_OE  = d_oe;
  assign bus.AS_n  = as_n;
  assign bus.UDS_n = uds_n;
  assign bus.LDS_n = lds_n;
  assign bus.RW_n  = rw_n;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// tb_m68k_bus_initiator: scoreboard bench for m68k_bus_initiator with a memory-backed bus responder.
// A word-addressed reference memory predicts every ACK; a monitor pops and compares on each ACK.
// Build with BUS_TIMEOUT_EN defined to also exercise the timeout path with TIMEOUT_CYCLES=16.
module tb_m68k_bus_initiator;

  localparam int SYNC = 2;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  typedef struct {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  m68k_bus_initiator_if bus();

  m68k_bus_initiator #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required end before it", $time);
    $fatal(1);
  end

  // ---------------- reference model and responder memory ----------------
  exp_t        sb[$];
  logic [15:0] ref_mem [int];
  logic [15:0] bmem [int];
  logic [15:0] last_rdata = 16'h0000;

  function automatic logic [15:0] dflt(input logic [22:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [15:0] bus_rd(input logic [22:0] a);
    return bmem.exists(int'(a)) ? bmem[int'(a)] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- bus responder (only driver of D_IN/DTACK_n/BERR_n) ----------------
  bit resp_on    = 1'b1;
  bit resp_berr  = 1'b0;
  bit tie_dtack  = 1'b0;
  int resp_delay = 0;
  int resp_hold  = 0;
  int rel_cyc    = -1;
  int ds_cnt     = 0;
  int rel_cnt    = 0;
  bit r_done     = 1'b0;

  initial begin
    bus.DTACK_n = 1'b1;
    bus.BERR_n  = 1'b1;
    bus.D_IN    = 16'h0000;
    forever begin
      @(negedge CLK);
      if (tie_dtack) bus.DTACK_n = 1'b0;
      if (!bus.AS_n && (!bus.UDS_n || !bus.LDS_n)) begin
        rel_cnt = 0;
        if (bus.RW_n) bus.D_IN = bus_rd(bus.A_OUT);
        if (resp_on && !r_done && ds_cnt >= resp_delay) begin
          r_done = 1'b1;
          bus.DTACK_n = 1'b0;
          if (resp_berr) begin
            bus.BERR_n = 1'b0;
          end else if (!bus.RW_n) begin
            logic [15:0] old;
            old = bus_rd(bus.A_OUT);
            bmem[int'(bus.A_OUT)] = {!bus.UDS_n ? bus.D_OUT[15:8] : old[15:8],
                                     !bus.LDS_n ? bus.D_OUT[7:0]  : old[7:0]};
          end
        end
        ds_cnt++;
      end else if (bus.AS_n) begin
        ds_cnt = 0;
        r_done = 1'b0;
        bus.D_IN = 16'($urandom);
        if (!tie_dtack && (!bus.DTACK_n || !bus.BERR_n)) begin
          if (rel_cnt >= resp_hold) begin
            bus.DTACK_n = 1'b1;
            bus.BERR_n  = 1'b1;
            rel_cyc     = cyc;
          end
          rel_cnt++;
        end
      end
    end
  end

  // ---------------- monitor: pops the scoreboard on every ACK ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET_n && bus.ACK) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got ACK=1 required no ACK (scoreboard empty)");
        end else begin
          e = sb.pop_front();
          chk("ack_err", bus.ERR, e.err);
          chk("ack_rdata", bus.RDATA, e.rdata);
          chk("ack_strobes_negated", {bus.AS_n, bus.UDS_n, bus.LDS_n, bus.RW_n}, 4'b1111);
          chk("ack_doe_off", bus.D_OE, 1'b0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          t_as, t_ds, t_oe, t_ack;
  bit          t_uds, t_lds;
  logic [22:0] t_addr;
  logic        t_rw;
  logic [15:0] t_dout;

  // Waits until the responder has released and the release has crossed the synchroniser.
  task automatic settle();
    int n = 0;
    while (!(bus.DTACK_n && bus.BERR_n) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!(bus.DTACK_n && bus.BERR_n)) chk("settle_release", {bus.DTACK_n, bus.BERR_n}, 2'b11);
    repeat (SYNC + 2) @(negedge CLK);
  endtask

  task automatic issue(input bit rd, input logic [22:0] a, input logic [1:0] be,
                       input logic [15:0] wd, input bit err, input int exp_lat, input bit keep);
    exp_t e;
    int   start;
    bit   got;
    logic [15:0] old;
    if (rd && !err) last_rdata = ref_rd(a);
    if (!rd && !err) begin
      old = ref_rd(a);
      ref_mem[int'(a)] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    end
    e.err   = err;
    e.rdata = last_rdata;
    sb.push_back(e);
    @(negedge CLK);
    bus.REQ = 1'b1; bus.REQ_RW = rd; bus.REQ_ADDR = a; bus.REQ_BE = be; bus.REQ_WDATA = wd;
    start = cyc;
    t_as = -1; t_ds = -1; t_oe = -1; t_ack = -1; t_uds = 0; t_lds = 0; got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (t_oe < 0 && bus.D_OE) t_oe = cyc;
      if (t_as < 0 && !bus.AS_n) begin t_as = cyc; t_addr = bus.A_OUT; t_rw = bus.RW_n; end
      if (t_ds < 0 && (!bus.UDS_n || !bus.LDS_n)) begin t_ds = cyc; t_dout = bus.D_OUT; end
      if (!bus.UDS_n) t_uds = 1;
      if (!bus.LDS_n) t_lds = 1;
      if (bus.ACK) begin got = 1; t_ack = cyc; break; end
      // Once the cycle has started the request fields must no longer matter.
      if (t_as >= 0 && !keep) begin
        bus.REQ_RW = ~rd; bus.REQ_ADDR = 23'($urandom); bus.REQ_WDATA = 16'($urandom);
      end
    end
    if (!keep) bus.REQ = 1'b0;
    chk("ack_seen", got, 1'b1);
    if (got && exp_lat >= 0) chk("latency", t_ack - start, exp_lat);
    if (got) begin
      chk("bus_addr", t_addr, a);
      chk("bus_rw", t_rw, rd);
    end
  endtask

  initial begin
    bit rd;
    logic [22:0] a;
    logic [1:0] be;
    logic [15:0] wd;

    RESET_n = 1'b0;
    bus.REQ = 1'b0; bus.REQ_RW = 1'b1; bus.REQ_ADDR = '0; bus.REQ_BE = 2'b11; bus.REQ_WDATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_strobes", {bus.AS_n, bus.UDS_n, bus.LDS_n, bus.RW_n}, 4'b1111);
    chk("rst_doe_ack_err", {bus.D_OE, bus.ACK, bus.ERR}, 3'b000);
    chk("rst_a_out", bus.A_OUT, 23'h0);
    chk("rst_d_out_rdata", {bus.D_OUT, bus.RDATA}, 32'h0);
    RESET_n = 1'b1;
    settle();

    // Zero-wait read of a known word: DTACK answers the strobes, so the synchroniser adds SYNC-1.
    bmem[int'(23'h100000)] = 16'hBEEF;
    ref_mem[int'(23'h100000)] = 16'hBEEF;
    issue(1, 23'h100000, 2'b11, 16'h0, 0, 5 + SYNC - 1, 0);
    chk("rd_ds_with_as", t_ds - t_as, 0);
    chk("rd_both_ds", {t_uds, t_lds}, 2'b11);

    // Lower-byte write: LDS one CLK after AS, D_OE already on, UDS untouched.
    settle();
    issue(0, 23'h000007, 2'b01, 16'h00A5, 0, 6 + SYNC - 1, 0);
    chk("wr_lds_after_as", t_ds - t_as, 1);
    chk("wr_lanes", {t_uds, t_lds}, 2'b01);
    chk("wr_oe_before_ds", (t_oe >= 0 && t_oe < t_ds), 1'b1);
    chk("wr_d_out", t_dout, 16'h00A5);
    settle();
    issue(1, 23'h000007, 2'b11, 16'h0, 0, 5 + SYNC - 1, 0);

    // DTACK already low on entry to WAIT: the minimum 5-CLK read.
    tie_dtack = 1'b1;
    repeat (SYNC + 2) @(negedge CLK);
    issue(1, 23'h000005, 2'b11, 16'h0, 0, 5, 0);
    tie_dtack = 1'b0;
    settle();

    // Slow responder that keeps DTACK low 4 CLK past ACK while REQ stays high.
    resp_delay = 10; resp_hold = 4;
    issue(1, 23'h000003, 2'b10, 16'h0, 0, 5 + SYNC - 1 + 10, 1);
    issue(1, 23'h000003, 2'b10, 16'h0, 0, -1, 0);
    chk("no_as_before_release", t_as - rel_cyc, SYNC + 3);
    resp_delay = 0; resp_hold = 0;
    settle();

    // BERR and DTACK together: error completion, RDATA keeps the previous read.
    resp_berr = 1'b1;
    issue(1, 23'h000002, 2'b11, 16'h0, 1, 5 + SYNC - 1, 0);
    resp_berr = 1'b0;
    settle();

`ifdef BUS_TIMEOUT_EN
    resp_on = 1'b0;
    issue(1, 23'h000009, 2'b11, 16'h0, 1, 3 + TMO, 0);
    resp_on = 1'b1;
    settle();
`endif

    // Reset pulsed while waiting in WAIT on a write.
    resp_on = 1'b0;
    @(negedge CLK);
    bus.REQ = 1'b1; bus.REQ_RW = 1'b0; bus.REQ_ADDR = 23'h00000A; bus.REQ_BE = 2'b11; bus.REQ_WDATA = 16'h1234;
    repeat (7) @(negedge CLK);
    chk("pre_rst_in_cycle", {bus.AS_n, bus.D_OE}, 2'b01);
    RESET_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {bus.AS_n, bus.UDS_n, bus.LDS_n, bus.RW_n}, 4'b1111);
    chk("rst_mid_doe", bus.D_OE, 1'b0);
    bus.REQ = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_n = 1'b1;
    last_rdata = 16'h0000;
    resp_on = 1'b1;
    repeat (SYNC + 2) @(negedge CLK);
    chk("rst_mid_rdata", bus.RDATA, 16'h0);
    issue(1, 23'h00000A, 2'b11, 16'h0, 0, 5 + SYNC - 1, 0);

    // Randomised mix over a small address window so reads revisit written words.
    for (int n = 0; n < 40; n++) begin
      settle();
      rd         = 1'($urandom);
      a          = 23'($urandom_range(0, 15));
      be         = 2'($urandom_range(1, 3));
      wd         = 16'($urandom);
      resp_delay = $urandom_range(0, 3);
      resp_berr  = ($urandom_range(0, 7) == 0);
      issue(rd, a, be, wd, resp_berr, (rd ? 5 : 6) + SYNC - 1 + resp_delay, 0);
    end
    resp_berr = 1'b0;
    settle();

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
